// File: rtl/mem_port_arbiter.sv
// Arbitrates the shared memory port between instruction fetch (I) and load/store (D).
// D has priority with an I starvation guard; a watchdog aborts accesses that never see mem_ready_i.
module mem_port_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = 3,
  parameter int WAIT_MAX   = 16,
  parameter int WAIT_W     = 5
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic ireq_i,
  input  logic dreq_i,
  input  logic dwrite_i,
  input  logic mem_ready_i,
  output logic sel_o,
  output logic mem_en_o,
  output logic mem_we_o,
  output logic idone_o,
  output logic ddone_o,
  output logic busy_o,
  output logic err_o
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_BUSY_I = 2'd1;
  localparam logic [1:0] S_BUSY_D = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  streak_q, streak_d;
  logic [WAIT_W-1:0] wcnt_q, wcnt_d;
  logic              err_q, err_d;
  logic              wr_q, wr_d;
  logic              sel_q, sel_d;
  logic              en_q, en_d;

  logic busy, timeout, done, arb, ireq_m, dreq_m;

  assign busy    = (state_q != S_IDLE);
  assign timeout = (wcnt_q == WAIT_W'(WAIT_MAX - 1));
  assign done    = busy & (mem_ready_i | timeout);
  assign idone_o = (state_q == S_BUSY_I) & done;
  assign ddone_o = (state_q == S_BUSY_D) & done;
  assign arb     = ~busy | done;
  // The completing requester still holds Req this cycle; it must not win again.
  assign ireq_m  = ireq_i & ~idone_o;
  assign dreq_m  = dreq_i & ~ddone_o;

  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    wcnt_d   = wcnt_q;
    err_d    = err_q;
    wr_d     = wr_q;
    sel_d    = sel_q;
    en_d     = 1'b0;
    if (busy && !done) wcnt_d = wcnt_q + 1'b1;
    if (done && timeout && !mem_ready_i) err_d = 1'b1;
    if (arb) begin
      state_d = S_IDLE;
      sel_d   = 1'b0;
      wr_d    = 1'b0;
      wcnt_d  = '0;
      if (dreq_m && !(ireq_m && streak_q == CNT_W'(STARVE_MAX))) begin
        state_d  = S_BUSY_D;
        sel_d    = 1'b1;
        en_d     = 1'b1;
        wr_d     = dwrite_i;
        // Cannot exceed STARVE_MAX: at the limit with I waiting, I wins instead.
        streak_d = ireq_m ? streak_q + 1'b1 : '0;
      end else if (ireq_m) begin
        state_d  = S_BUSY_I;
        en_d     = 1'b1;
        streak_d = '0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      streak_q <= '0;
      wcnt_q   <= '0;
      err_q    <= 1'b0;
      wr_q     <= 1'b0;
      sel_q    <= 1'b0;
      en_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      wcnt_q   <= wcnt_d;
      err_q    <= err_d;
      wr_q     <= wr_d;
      sel_q    <= sel_d;
      en_q     <= en_d;
    end
  end

  assign sel_o    = sel_q;
  assign mem_en_o = en_q;
  assign mem_we_o = en_q & wr_q;
  assign busy_o   = busy;
  assign err_o    = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a transaction-level port-ownership model
// predicts each cycle's outputs, and a monitor process compares them against the DUT.
module tb_mem_port_arbiter;
  localparam int STARVE = 4;
  localparam int WMAX   = 16;

  logic clk = 1'b0, rst_n = 1'b0;
  logic ireq = 0, dreq = 0, dwrite = 0, mready = 0;
  logic sel, men, mwe, idone, ddone, busy, err;

  mem_port_arbiter #(.STARVE_MAX(STARVE), .CNT_W(3), .WAIT_MAX(WMAX), .WAIT_W(5)) dut (
    .clk_i(clk), .rst_ni(rst_n), .ireq_i(ireq), .dreq_i(dreq), .dwrite_i(dwrite),
    .mem_ready_i(mready), .sel_o(sel), .mem_en_o(men), .mem_we_o(mwe),
    .idone_o(idone), .ddone_o(ddone), .busy_o(busy), .err_o(err));

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  logic [6:0] exp_q[$];

  // Model: who owns the port (0 none, 1 fetch, 2 data), cycles spent in the access,
  // grant-time write flag, sticky error, consecutive D wins while I waited.
  int   m_own = 0, m_age = 0, m_streak = 0;
  logic m_wr = 0, m_err = 0;
  logic e_idone, e_ddone;

  task automatic model_reset();
    m_own = 0; m_age = 0; m_streak = 0; m_wr = 0; m_err = 0;
    exp_q.delete();
  endtask

  task automatic cyc(input logic i, input logic d, input logic w, input logic r);
    logic b, first, tmo, dn, ie, de;
    @(negedge clk);
    ireq = i; dreq = d; dwrite = w; mready = r;
    b     = (m_own != 0);
    first = b && (m_age == 0);
    tmo   = b && (m_age == WMAX - 1);
    dn    = b && (r || tmo);
    e_idone = dn && m_own == 1;
    e_ddone = dn && m_own == 2;
    exp_q.push_back({m_own == 2, first, first && m_own == 2 && m_wr, e_idone, e_ddone, b, m_err});
    if (dn && !r) m_err = 1;
    if (!b || dn) begin
      ie = i && !e_idone;
      de = d && !e_ddone;
      if (de && !(ie && m_streak >= STARVE)) begin
        m_own = 2; m_age = 0; m_wr = w;
        m_streak = ie ? ((m_streak + 1 > STARVE) ? STARVE : m_streak + 1) : 0;
      end else if (ie) begin
        m_own = 1; m_age = 0; m_streak = 0;
      end else begin
        m_own = 0; m_age = 0;
      end
    end else begin
      m_age = m_age + 1;
    end
  endtask

  task automatic check_direct(input string nm, input logic [6:0] got, input logic [6:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %b want %b (sel,en,we,idone,ddone,busy,err)", nm, got, want);
    end
  endtask

  // Monitor: compare every cycle the DUT is observed out of reset.
  initial begin
    logic [6:0] want;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        want = exp_q.pop_front();
        n_chk++;
        if ({sel, men, mwe, idone, ddone, busy, err} !== want) begin
          n_fail++;
          $display("FAIL cycle_outputs @%0t: got %b want %b (sel,en,we,idone,ddone,busy,err)",
                   $time, {sel, men, mwe, idone, ddone, busy, err}, want);
        end
      end
    end
  end

  initial begin
    logic ir, dr;
    #12;
    check_direct("reset_state", {sel, men, mwe, idone, ddone, busy, err}, 7'b0);
    @(negedge clk); #3 rst_n = 1;

    // Fetch only, memory ready in the third access cycle
    cyc(1,0,0,0); cyc(1,0,0,0); cyc(1,0,0,0); cyc(1,0,0,1); cyc(0,0,0,0); cyc(0,0,0,0);
    // Simultaneous requests, store first, then fetch back-to-back
    cyc(1,1,1,0); cyc(1,1,0,0); cyc(1,1,0,1); cyc(1,0,0,1); cyc(0,0,0,0);
    // Both held with memory always ready
    for (int k = 0; k < 10; k++) cyc(1,1,k[0],1);
    cyc(0,0,0,0); cyc(0,0,0,0);
    // Zero-wait data access; no re-grant afterwards
    cyc(0,1,0,0); cyc(0,1,0,1); cyc(0,0,0,0); cyc(0,0,0,0);
    // Fetch that never sees ready: watchdog abort, then a normal store
    cyc(1,0,0,0);
    for (int k = 0; k < WMAX; k++) cyc(1,0,0,0);
    cyc(0,0,0,0); cyc(0,1,1,0); cyc(0,1,0,0); cyc(0,1,0,1); cyc(0,0,0,0); cyc(0,0,0,0);
    // Request dropped mid-access still completes; DWrite change after grant ignored
    cyc(0,1,1,0); cyc(0,0,0,0); cyc(0,0,0,0); cyc(0,0,0,1); cyc(0,0,0,0);

    // Asynchronous reset in the middle of a store
    cyc(0,1,1,0); cyc(0,1,1,0);
    #3 rst_n = 0;
    #1 check_direct("async_reset", {sel, men, mwe, idone, ddone, busy, err}, 7'b0);
    model_reset();
    ireq = 0; dreq = 0; mready = 0;
    @(negedge clk); #3 rst_n = 1;
    cyc(0,0,0,0); cyc(0,0,0,0);

    // Randomized traffic with requester protocol and occasional stalls
    ir = 0; dr = 0;
    for (int n = 0; n < 3000; n++) begin
      logic r;
      if (!ir && $urandom_range(0,2) == 0) ir = 1;
      if (!dr && $urandom_range(0,2) == 0) dr = 1;
      if ((n % 600) < 40) r = 0;
      else r = ($urandom_range(0,2) != 0);
      cyc(ir, dr, 1'($urandom), r);
      if (e_idone) ir = ($urandom_range(0,3) == 0);
      if (e_ddone) dr = ($urandom_range(0,3) == 0);
      if ($urandom_range(0,99) == 0) ir = 0;
      if ($urandom_range(0,99) == 0) dr = 0;
    end
    cyc(0,0,0,0);
    repeat (2) @(negedge clk);
    #4;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
